// File: rtl/ir_motor_pkg.sv
// Shared types and constants for the IR-triggered motor controller.
package ir_motor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    BRAKE = 2'd2
  } state_e;

  // H-bridge direction pair encodings: {high_side, low_side} per channel.
  localparam logic [1:0] DIR_FWD = 2'b10;
  localparam logic [1:0] DIR_REV = 2'b01;
  localparam logic [1:0] DIR_BRK = 2'b11;

endpackage

// File: rtl/ir_debounce.sv
// Two-flop synchroniser and saturating low-level debounce for the IR pin.
// trig is a level: it stays high while the synchronised line stays low
// for at least DEB_CYCLES cycles.
module ir_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic ir_signal,
  output logic see,
  output logic trig
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYCLES);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [DW-1:0] deb_q, deb_d;

  // Next-state: shift the synchroniser, count low cycles, clear on any high.
  always_comb begin
    sync1_d = ir_signal;
    sync2_d = sync1_q;
    deb_d   = deb_q;
    if (sync2_q) begin
      deb_d = '0;
    end else if (deb_q != DEB_MAX) begin
      deb_d = deb_q + DW'(1);
    end
  end

  // Synchroniser resets idle-high so the debug LED reads inactive.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      deb_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      deb_q   <= deb_d;
    end
  end

  assign see  = sync2_q;
  assign trig = (deb_q == DEB_MAX);

endmodule

// File: rtl/ir_motor_ctrl.sv
// IR-triggered timed motor run: IDLE -> RUN (retriggerable) -> BRAKE -> IDLE.
// All outputs are registered; run/gogo/busy are computed from next-state.
// Optional macro IR_MOTOR_SOFTSTART_EN ramps the PWM duty up after each
// IDLE -> RUN entry.
module ir_motor_ctrl
  import ir_motor_pkg::*;
#(
  parameter int N_CH         = 2,
  parameter int CNT_W        = 31,
  parameter int RUN_CYCLES   = 10_000_000,
  parameter int DEB_CYCLES   = 4,
  parameter int BRAKE_CYCLES = 1000,
  parameter int PWM_W        = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ir_signal,
  input  logic [N_CH-1:0]   dir_req,
  input  logic [PWM_W-1:0]  duty,
  output logic [N_CH-1:0]   run,
  output logic [2*N_CH-1:0] gogo,
  output logic              busy,
  output logic              see
);

  localparam int BCW = (BRAKE_CYCLES < 2) ? 1 : $clog2(BRAKE_CYCLES + 1);
  localparam logic [CNT_W-1:0] RUN_RELOAD   = CNT_W'(RUN_CYCLES);
  localparam logic [BCW-1:0]   BRAKE_RELOAD = BCW'(BRAKE_CYCLES);

  logic trig;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BCW-1:0]     bcnt_q, bcnt_d;
  logic [N_CH-1:0]    dir_q, dir_d;
  logic [PWM_W-1:0]   pwm_cnt_q, pwm_cnt_d;
  logic [PWM_W-1:0]   eff_duty_q, eff_duty_d;
  logic [N_CH-1:0]    run_q, run_d;
  logic [2*N_CH-1:0]  gogo_q, gogo_d;
  logic               busy_q, busy_d;
  logic               pwm_on_d;

  ir_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_debounce (
    .clk       (clk),
    .rst       (rst),
    .ir_signal (ir_signal),
    .see       (see),
    .trig      (trig)
  );

  // FSM next-state: a trig in RUN reloads the timer and wins over expiry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bcnt_d  = bcnt_q;
    dir_d   = dir_q;
    case (state_q)
      IDLE: begin
        if (trig) begin
          state_d = RUN;
          cnt_d   = RUN_RELOAD;
          dir_d   = dir_req;
        end
      end
      RUN: begin
        if (trig) begin
          cnt_d = RUN_RELOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            if (BRAKE_CYCLES == 0) begin
              state_d = IDLE;
            end else begin
              state_d = BRAKE;
              bcnt_d  = BRAKE_RELOAD;
            end
          end
        end
      end
      BRAKE: begin
        bcnt_d = bcnt_q - BCW'(1);
        if (bcnt_q == BCW'(1)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // PWM: free-running counter; effective duty only changes at counter zero.
  always_comb begin
    pwm_cnt_d  = pwm_cnt_q + PWM_W'(1);
    eff_duty_d = eff_duty_q;
`ifdef IR_MOTOR_SOFTSTART_EN
    if (state_q == IDLE && trig) begin
      eff_duty_d = '0;
    end else if (pwm_cnt_q == '0) begin
      if (duty < eff_duty_q) begin
        eff_duty_d = duty;
      end else if (eff_duty_q < duty) begin
        eff_duty_d = eff_duty_q + PWM_W'(1);
      end
    end
`else
    if (pwm_cnt_q == '0) begin
      eff_duty_d = duty;
    end
`endif
    pwm_on_d = (pwm_cnt_d < eff_duty_d);
  end

  // Output decode from next-state so the registered pins track the state.
  always_comb begin
    busy_d = (state_d != IDLE);
    run_d  = '0;
    gogo_d = '1;
    for (int i = 0; i < N_CH; i++) begin
      if (state_d == RUN) begin
        gogo_d[2*i +: 2] = dir_d[i] ? DIR_FWD : DIR_REV;
        run_d[i]         = pwm_on_d;
      end else begin
        gogo_d[2*i +: 2] = DIR_BRK;
      end
    end
  end

  // State and output registers; reset abandons any run without braking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bcnt_q     <= '0;
      dir_q      <= '1;
      pwm_cnt_q  <= '0;
      eff_duty_q <= '0;
      run_q      <= '0;
      gogo_q     <= '1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bcnt_q     <= bcnt_d;
      dir_q      <= dir_d;
      pwm_cnt_q  <= pwm_cnt_d;
      eff_duty_q <= eff_duty_d;
      run_q      <= run_d;
      gogo_q     <= gogo_d;
      busy_q     <= busy_d;
    end
  end

  assign run  = run_q;
  assign gogo = gogo_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_ir_motor_ctrl.sv
// Directed bench for ir_motor_ctrl with RUN_CYCLES=20, DEB_CYCLES=3,
// BRAKE_CYCLES=5, PWM_W=4. Inputs change on the falling edge, outputs are
// sampled on the falling edge after each rising edge. Edge e of a scenario
// is the e-th rising edge after the scenario starts; ir_signal driven for
// step e is the value seen at edge e.
module tb_ir_motor_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ir_signal = 1'b1;
  logic [1:0] dir_req = 2'b01;
  logic [3:0] duty = 4'd8;
  logic [1:0] run;
  logic [3:0] gogo;
  logic       busy;
  logic       see;

  int checks = 0;
  int passed = 0;
  int cyc = 0;

  ir_motor_ctrl #(
    .N_CH         (2),
    .CNT_W        (31),
    .RUN_CYCLES   (20),
    .DEB_CYCLES   (3),
    .BRAKE_CYCLES (5),
    .PWM_W        (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ir_signal (ir_signal),
    .dir_req   (dir_req),
    .duty      (duty),
    .run       (run),
    .gogo      (gogo),
    .busy      (busy),
    .see       (see)
  );

  always #5 clk = ~clk;

  // One clock: cyc counts edges since reset release (PWM phase = cyc % 16).
  task automatic step();
    @(posedge clk);
    if (rst) cyc = 0;
    else cyc++;
    @(negedge clk);
  endtask

  task automatic idle_steps(input int n);
    ir_signal = 1'b1;
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ir_signal = 1'b1;
    for (int k = 0; k < 3; k++) step();
    checks++; if (run !== 2'b00) $display("FAIL reset_run got=%b exp=00", run); else passed++;
    checks++; if (gogo !== 4'b1111) $display("FAIL reset_gogo got=%b exp=1111", gogo); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
    checks++; if (see !== 1'b1) $display("FAIL reset_see got=%b exp=1", see); else passed++;
    rst = 1'b0;
    idle_steps(4);
  endtask

  // Low for 1 cycle, then low for 2 cycles: neither reaches DEB_CYCLES.
  task automatic test_noise();
    logic [11:0] pat;
    pat = 12'b111111001110;
    for (int e = 0; e < 12; e++) begin
      ir_signal = pat[e];
      step();
      checks++; if (busy !== 1'b0) $display("FAIL noise_busy e=%0d got=%b exp=0", e, busy); else passed++;
    end
    idle_steps(4);
  endtask

  // 4-cycle pulse: RUN at edges 6..26, BRAKE 27..31, IDLE from 32.
  task automatic test_single_pulse();
    logic rp, eb, es;
    logic [3:0] eg;
    logic [1:0] er;
    int ones;
    dir_req = 2'b01;
    ones = 0;
    for (int e = 1; e <= 40; e++) begin
      ir_signal = (e <= 4) ? 1'b0 : 1'b1;
      step();
      rp = (e >= 6 && e <= 26);
      eb = (e >= 6 && e <= 31);
      es = !(e >= 2 && e <= 5);
      eg = rp ? 4'b0110 : 4'b1111;
      er = (rp && (cyc % 16) < 8) ? 2'b11 : 2'b00;
      checks++; if (busy !== eb) $display("FAIL pulse_busy e=%0d got=%b exp=%b", e, busy, eb); else passed++;
      checks++; if (gogo !== eg) $display("FAIL pulse_gogo e=%0d got=%b exp=%b", e, gogo, eg); else passed++;
      checks++; if (see !== es) $display("FAIL pulse_see e=%0d got=%b exp=%b", e, see, es); else passed++;
`ifdef IR_MOTOR_SOFTSTART_EN
      if (!rp) begin
        checks++; if (run !== 2'b00) $display("FAIL pulse_run e=%0d got=%b exp=00", e, run); else passed++;
      end
`else
      checks++; if (run !== er) $display("FAIL pulse_run e=%0d got=%b exp=%b", e, run, er); else passed++;
      if (e >= 7 && e <= 22 && run[0]) ones++;
`endif
    end
`ifndef IR_MOTOR_SOFTSTART_EN
    checks++; if (ones != 8) $display("FAIL pulse_duty_count got=%0d exp=8", ones); else passed++;
`endif
    idle_steps(4);
  endtask

  // Second pulse reloads at edge 25 (cnt was 3); last reload edge 26.
  // dir_req changes mid-run and must not be re-latched.
  task automatic test_retrigger();
    logic rp, eb;
    logic [3:0] eg;
    dir_req = 2'b01;
    for (int e = 1; e <= 55; e++) begin
      ir_signal = ((e <= 4) || (e >= 20 && e <= 23)) ? 1'b0 : 1'b1;
      if (e == 15) dir_req = 2'b10;
      step();
      rp = (e >= 6 && e <= 45);
      eb = (e >= 6 && e <= 50);
      eg = rp ? 4'b0110 : 4'b1111;
      checks++; if (busy !== eb) $display("FAIL retrig_busy e=%0d got=%b exp=%b", e, busy, eb); else passed++;
      checks++; if (gogo !== eg) $display("FAIL retrig_gogo e=%0d got=%b exp=%b", e, gogo, eg); else passed++;
    end
    idle_steps(4);
  endtask

  // Pulse during BRAKE is ignored; a line still low at IDLE restarts RUN.
  task automatic test_brake_trigger();
    logic rp, eb;
    logic [3:0] eg;
    dir_req = 2'b01;
    for (int e = 1; e <= 40; e++) begin
      ir_signal = ((e <= 4) || (e >= 23 && e <= 26)) ? 1'b0 : 1'b1;
      step();
      rp = (e >= 6 && e <= 26);
      eb = (e >= 6 && e <= 31);
      checks++; if (busy !== eb) $display("FAIL brk_ign_busy e=%0d got=%b exp=%b", e, busy, eb); else passed++;
      if (e >= 27 && e <= 31) begin
        checks++; if (gogo !== 4'b1111) $display("FAIL brk_ign_gogo e=%0d got=%b exp=1111", e, gogo); else passed++;
        checks++; if (run !== 2'b00) $display("FAIL brk_ign_run e=%0d got=%b exp=00", e, run); else passed++;
      end
    end
    idle_steps(4);
    for (int e = 1; e <= 72; e++) begin
      ir_signal = ((e <= 4) || (e >= 23 && e <= 40)) ? 1'b0 : 1'b1;
      step();
      rp = (e >= 6 && e <= 26) || (e >= 33 && e <= 62);
      eb = (e >= 6 && e <= 31) || (e >= 33 && e <= 67);
      eg = rp ? 4'b0110 : 4'b1111;
      checks++; if (busy !== eb) $display("FAIL brk_hold_busy e=%0d got=%b exp=%b", e, busy, eb); else passed++;
      checks++; if (gogo !== eg) $display("FAIL brk_hold_gogo e=%0d got=%b exp=%b", e, gogo, eg); else passed++;
    end
    idle_steps(4);
  endtask

  // Reset mid-RUN drops straight to idle outputs with no BRAKE.
  task automatic test_reset_mid_run();
    dir_req = 2'b01;
    for (int e = 1; e <= 9; e++) begin
      ir_signal = (e <= 4) ? 1'b0 : 1'b1;
      step();
    end
    checks++; if (busy !== 1'b1) $display("FAIL rstmid_pre_busy got=%b exp=1", busy); else passed++;
    rst = 1'b1;
    step();
    checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy got=%b exp=0", busy); else passed++;
    checks++; if (gogo !== 4'b1111) $display("FAIL rstmid_gogo got=%b exp=1111", gogo); else passed++;
    checks++; if (run !== 2'b00) $display("FAIL rstmid_run got=%b exp=00", run); else passed++;
    checks++; if (see !== 1'b1) $display("FAIL rstmid_see got=%b exp=1", see); else passed++;
    rst = 1'b0;
    for (int e = 11; e <= 20; e++) begin
      step();
      checks++; if (busy !== 1'b0) $display("FAIL rstmid_after_busy e=%0d got=%b exp=0", e, busy); else passed++;
      checks++; if (gogo !== 4'b1111) $display("FAIL rstmid_after_gogo e=%0d got=%b exp=1111", e, gogo); else passed++;
    end
    idle_steps(4);
  endtask

  // duty=0 keeps run low; new dir_req is latched on this entry.
  task automatic test_duty_zero();
    logic rp;
    logic [3:0] eg;
    duty = 4'd0;
    dir_req = 2'b10;
    idle_steps(20);
    for (int e = 1; e <= 35; e++) begin
      ir_signal = (e <= 4) ? 1'b0 : 1'b1;
      step();
      rp = (e >= 6 && e <= 26);
      eg = rp ? 4'b1001 : 4'b1111;
      checks++; if (run !== 2'b00) $display("FAIL duty0_run e=%0d got=%b exp=00", e, run); else passed++;
      checks++; if (gogo !== eg) $display("FAIL duty0_gogo e=%0d got=%b exp=%b", e, gogo, eg); else passed++;
    end
    duty = 4'd8;
    dir_req = 2'b01;
    idle_steps(20);
  endtask

  // Entry placed at PWM phase 4; reloads happen at e=19,35,... Count run
  // highs per 16-cycle window: ramps 1..8 with soft-start, else always 8.
  task automatic test_pwm_ramp();
    int ones;
    int expd;
    int k;
    dir_req = 2'b01;
    duty = 4'd8;
    ir_signal = 1'b1;
    for (k = 0; k < 17 && (cyc % 16) != 14; k++) step();
    checks++; if ((cyc % 16) != 14) $display("FAIL ramp_align got=%0d exp=14", cyc % 16); else passed++;
    ir_signal = 1'b0;
    for (int e = 1; e <= 18; e++) step();
    checks++; if (busy !== 1'b1) $display("FAIL ramp_busy got=%b exp=1", busy); else passed++;
    for (int w = 0; w < 10; w++) begin
      ones = 0;
      for (int j = 0; j < 16; j++) begin
        step();
        if (run === 2'b11) ones++;
      end
`ifdef IR_MOTOR_SOFTSTART_EN
      expd = (w + 1 < 8) ? w + 1 : 8;
`else
      expd = 8;
`endif
      checks++; if (ones != expd) $display("FAIL ramp_window w=%0d got=%0d exp=%0d", w, ones, expd); else passed++;
    end
    ir_signal = 1'b1;
    for (k = 0; k < 60 && busy; k++) step();
    checks++; if (busy !== 1'b0) $display("FAIL ramp_timeout busy=%b exp=0", busy); else passed++;
    idle_steps(4);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_noise();
    test_single_pulse();
    test_retrigger();
    test_brake_trigger();
    test_reset_mid_run();
    test_duty_zero();
    test_pwm_ramp();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
